// File: rtl/axi_lite_svm_ctrl.sv
// axi_lite_svm_ctrl: AXI4-Lite register/control block for the linear SVM core; define SVM_IRQ_EN to enable IRQ_EN/IRQ_STAT and irq
module axi_lite_svm_ctrl #(
  parameter int NUM_FEATURES = 20,
  parameter int DATA_WIDTH = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 9
) (
  input  logic                                s_axi_aclk,
  input  logic                                s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s_axi_awaddr,
  input  logic [2:0]                          s_axi_awprot,
  input  logic                                s_axi_awvalid,
  output logic                                s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s_axi_wdata,
  input  logic [3:0]                          s_axi_wstrb,
  input  logic                                s_axi_wvalid,
  output logic                                s_axi_wready,
  output logic [1:0]                          s_axi_bresp,
  output logic                                s_axi_bvalid,
  input  logic                                s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s_axi_araddr,
  input  logic [2:0]                          s_axi_arprot,
  input  logic                                s_axi_arvalid,
  output logic                                s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s_axi_rdata,
  output logic [1:0]                          s_axi_rresp,
  output logic                                s_axi_rvalid,
  input  logic                                s_axi_rready,
  output logic                                core_start,
  output logic                                core_rst,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0]  core_features_flat,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0]  core_weights_flat,
  output logic [DATA_WIDTH-1:0]               core_bias,
  input  logic                                core_done,
  input  logic [DATA_WIDTH-1:0]               core_decision,
  input  logic                                core_prediction,
  output logic                                irq
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NF = NUM_FEATURES;
  localparam int DW = DATA_WIDTH;
  localparam int IW = NF > 1 ? $clog2(NF) : 1;
  logic aw_held, w_held, done, busy, pred, start_dropped, start_req, soft_req, irq_en, irq_stat;
  logic [AW-1:0] aw_addr;
  logic [31:0] w_data, bias, result, latency, infer_count, lat_cnt, rd_val;
  logic [3:0] w_strb;
  logic [31:0] weights [NF];
  logic [31:0] features [NF];
  logic w_wt, w_ft, r_wt, r_ft, wr_ok, rd_ok;
  int wi, ri;
  logic unused;
  assign unused = ^{s_axi_awprot, s_axi_arprot, aw_addr[1:0], s_axi_araddr[1:0]};
  assign s_axi_awready = ~aw_held & ~s_axi_bvalid & ~s_axi_areset;
  assign s_axi_wready = ~w_held & ~s_axi_bvalid & ~s_axi_areset;
  assign s_axi_arready = ~s_axi_rvalid & ~s_axi_areset;
  assign core_bias = bias[DW-1:0];
  for (genvar k = 0; k < NF; k++) begin : g_flat
    assign core_weights_flat[k*DW +: DW] = weights[k][DW-1:0];
    assign core_features_flat[k*DW +: DW] = features[k][DW-1:0];
  end
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return m;
  endfunction
  always_comb begin
    wi = int'(aw_addr[AW-1:2]);
    ri = int'(s_axi_araddr[AW-1:2]);
    w_wt = wi >= 32 && wi < 32 + NF;
    w_ft = wi >= 64 && wi < 64 + NF;
    r_wt = ri >= 32 && ri < 32 + NF;
    r_ft = ri >= 64 && ri < 64 + NF;
    wr_ok = wi == 0 || wi == 5 || wi == 6 || ((wi == 4 || w_wt || w_ft) && !busy);
    rd_ok = ri < 8 || r_wt || r_ft;
    rd_val = '0;
    if (r_wt) rd_val = weights[s_axi_araddr[IW+1:2]];
    else if (r_ft) rd_val = features[s_axi_araddr[IW+1:2]];
    else
      case (ri)
        1: rd_val = {28'b0, start_dropped, pred, busy, done};
        2: rd_val = result;
        3: rd_val = latency;
        4: rd_val = bias;
        5: rd_val = {31'b0, irq_en};
        6: rd_val = {31'b0, irq_stat};
        7: rd_val = infer_count;
        default: rd_val = '0;
      endcase
  end
  always_ff @(posedge s_axi_aclk)
    if (s_axi_areset) begin
      {aw_held, w_held, done, busy, pred, start_dropped, start_req, soft_req, irq_en, irq_stat} <= '0;
      {aw_addr, w_data, w_strb, bias, result, latency, infer_count, lat_cnt} <= '0;
      {s_axi_bvalid, s_axi_bresp, s_axi_rvalid, s_axi_rdata, s_axi_rresp, core_start, core_rst, irq} <= '0;
      for (int i = 0; i < NF; i++) begin
        weights[i] <= '0;
        features[i] <= '0;
      end
    end else begin
      core_start <= 1'b0;
      core_rst <= 1'b0;
      start_req <= 1'b0;
      soft_req <= 1'b0;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (aw_held && w_held) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= wr_ok ? 2'b00 : 2'b10;
        if (wr_ok) begin
          if (wi == 0) begin
            start_req <= w_strb[0] & w_data[0];
            soft_req <= w_strb[0] & w_data[1];
          end
          if (wi == 4) bias <= merge(bias, w_data, w_strb);
`ifdef SVM_IRQ_EN
          if (wi == 5 && w_strb[0]) irq_en <= w_data[0];
          if (wi == 6 && w_strb[0] && w_data[0]) irq_stat <= 1'b0;
`endif
          if (w_wt) weights[aw_addr[IW+1:2]] <= merge(weights[aw_addr[IW+1:2]], w_data, w_strb);
          if (w_ft) features[aw_addr[IW+1:2]] <= merge(features[aw_addr[IW+1:2]], w_data, w_strb);
        end
      end
      if (soft_req) begin
        core_rst <= 1'b1;
        busy <= 1'b0;
        lat_cnt <= '0;
      end else begin
        if (start_req && busy) start_dropped <= 1'b1;
        else if (start_req) begin
          core_start <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          start_dropped <= 1'b0;
          lat_cnt <= '0;
        end else if (busy && !core_start) lat_cnt <= lat_cnt + 32'd1;
        if (core_done && busy) begin
          done <= 1'b1;
          busy <= 1'b0;
          pred <= core_prediction;
          result <= 32'(signed'(core_decision));
          latency <= lat_cnt + 32'd1;
          infer_count <= infer_count + 32'd1;
`ifdef SVM_IRQ_EN
          irq_stat <= 1'b1;
`endif
        end
      end
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= rd_val;
        s_axi_rresp <= rd_ok ? 2'b00 : 2'b10;
      end else if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
`ifdef SVM_IRQ_EN
      irq <= irq_en & irq_stat;
`else
      irq <= 1'b0;
`endif
    end
endmodule

// File: tb/tb_axi_lite_svm_ctrl.sv
// tb_axi_lite_svm_ctrl: directed scoreboard bench for axi_lite_svm_ctrl
module tb_axi_lite_svm_ctrl;
  localparam int NF = 8;
  localparam int DW = 16;
`ifdef SVM_IRQ_EN
  localparam logic [31:0] IRQ = 32'd1;
`else
  localparam logic [31:0] IRQ = 32'd0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [8:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic core_start, core_rst, core_done, core_prediction, irq;
  logic [NF*DW-1:0] core_features_flat, core_weights_flat, wf;
  logic [DW-1:0] core_bias, core_decision;
  typedef struct {logic [31:0] d; logic [1:0] r;} exp_t;
  exp_t exp_q[$];
  int passed = 0;
  int total = 0;
  int starts = 0;
  int lat, n;
  always #5 clk = ~clk;
  always @(negedge clk) if (core_start) starts++;
  axi_lite_svm_ctrl #(.NUM_FEATURES(NF), .DATA_WIDTH(DW), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(9)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .core_start(core_start), .core_rst(core_rst), .core_features_flat(core_features_flat),
    .core_weights_flat(core_weights_flat), .core_bias(core_bias), .core_done(core_done),
    .core_decision(core_decision), .core_prediction(core_prediction), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er,
                    input int lead, input string tag, output int l);
    exp_t e;
    int k;
    e.d = '0;
    e.r = er;
    exp_q.push_back(e);
    awaddr = a;
    wdata = d;
    wstrb = s;
    k = 0;
    if (lead < 0) begin
      awvalid = 1'b1;
      wvalid = 1'b1;
      while (!(awready && wready) && k < 20) begin tick; k++; end
      tick;
      awvalid = 1'b0;
      wvalid = 1'b0;
    end else begin
      wvalid = 1'b1;
      while (!wready && k < 20) begin tick; k++; end
      tick;
      wvalid = 1'b0;
      repeat (lead) tick;
      awvalid = 1'b1;
      while (!awready && k < 40) begin tick; k++; end
      tick;
      awvalid = 1'b0;
    end
    l = 0;
    while (!bvalid && l < 20) begin tick; l++; end
    e = exp_q.pop_front();
    chk({tag, " bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, " bresp"}, 32'(bresp), 32'(e.r));
  endtask
  task automatic w(input logic [8:0] a, input logic [31:0] d, input logic [1:0] er, input string tag);
    int l;
    wr(a, d, 4'hF, er, -1, tag, l);
  endtask
  task automatic rd(input logic [8:0] a, input logic [31:0] ed, input logic [1:0] er, input string tag);
    exp_t e;
    int k;
    e.d = ed;
    e.r = er;
    exp_q.push_back(e);
    araddr = a;
    arvalid = 1'b1;
    k = 0;
    while (!arready && k < 20) begin tick; k++; end
    tick;
    arvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 20) begin tick; k++; end
    e = exp_q.pop_front();
    chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, " rdata"}, rdata, e.d);
    chk({tag, " rresp"}, 32'(rresp), 32'(e.r));
  endtask
  initial begin
    rst = 1'b1;
    {awaddr, araddr, awprot, arprot, awvalid, wvalid, arvalid, wdata, wstrb} = '0;
    {core_done, core_prediction, core_decision} = '0;
    bready = 1'b1;
    rready = 1'b1;
    repeat (3) tick;
    chk("reset awready", 32'(awready), 0);
    chk("reset wready", 32'(wready), 0);
    chk("reset arready", 32'(arready), 0);
    chk("reset core_start", 32'(core_start), 0);
    chk("reset irq", 32'(irq), 0);
    rst = 1'b0;
    tick;
    chk("post-reset awready", 32'(awready), 1);
    chk("post-reset wready", 32'(wready), 1);
    chk("post-reset arready", 32'(arready), 1);
    chk("post-reset bvalid", 32'(bvalid), 0);
    chk("post-reset features", 32'(core_features_flat == '0), 1);
    wr(9'h088, 32'h00000180, 4'hF, 2'b00, 3, "weight2", lat);
    chk("weight2 bvalid delay", 32'(lat), 1);
    wf = core_weights_flat;
    chk("weight2 flat", 32'(wf[47:32]), 32'h0180);
    rd(9'h088, 32'h00000180, 2'b00, "weight2");
    w(9'h010, 32'h11223344, 2'b00, "bias");
    wr(9'h010, 32'hAABBCCDD, 4'b0001, 2'b00, -1, "bias strb", lat);
    rd(9'h010, 32'h112233DD, 2'b00, "bias");
    chk("core_bias", 32'(core_bias), 32'h33DD);
    w(9'h0A0, 32'h5, 2'b10, "weight oob");
    rd(9'h0A0, 32'h0, 2'b10, "weight oob");
    w(9'h004, 32'h1, 2'b10, "status ro");
    w(9'h01C, 32'h1, 2'b10, "count ro");
    rd(9'h0FC, 32'h0, 2'b10, "unmapped");
    w(9'h100, 32'h00001234, 2'b00, "feat0");
    w(9'h11C, 32'hCAFE0042, 2'b00, "feat7");
    rd(9'h11C, 32'hCAFE0042, 2'b00, "feat7");
    wf = core_features_flat;
    chk("feat7 flat", 32'(wf[127:112]), 32'h0042);
    w(9'h014, 32'h1, 2'b00, "irq_en");
    rd(9'h014, IRQ, 2'b00, "irq_en");
    w(9'h000, 32'h1, 2'b00, "start");
    n = 0;
    while (!core_start && n < 20) begin tick; n++; end
    chk("core_start", 32'(core_start), 1);
    chk("core_start delay", 32'(n), 1);
    repeat (5) tick;
    core_decision = 16'hFF80;
    core_prediction = 1'b0;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("irq lag", 32'(irq), 0);
    tick;
    chk("irq", 32'(irq), IRQ);
    rd(9'h004, 32'h1, 2'b00, "status done");
    rd(9'h008, 32'hFFFFFF80, 2'b00, "result");
    rd(9'h00C, 32'd5, 2'b00, "latency");
    rd(9'h01C, 32'd1, 2'b00, "infer count");
    rd(9'h018, IRQ, 2'b00, "irq_stat");
    w(9'h018, 32'h1, 2'b00, "irq clear");
    rd(9'h018, 32'h0, 2'b00, "irq_stat cleared");
    chk("irq cleared", 32'(irq), 0);
    w(9'h000, 32'h1, 2'b00, "start2");
    n = 0;
    while (!core_start && n < 20) begin tick; n++; end
    chk("core_start2", 32'(core_start), 1);
    w(9'h000, 32'h1, 2'b00, "start busy");
    w(9'h100, 32'h0000BEEF, 2'b10, "feat0 locked");
    rd(9'h004, 32'hA, 2'b00, "status busy");
    rd(9'h100, 32'h00001234, 2'b00, "feat0 kept");
    chk("start pulses", 32'(starts), 2);
    w(9'h000, 32'h2, 2'b00, "soft");
    core_decision = 16'h0007;
    core_prediction = 1'b1;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    chk("core_rst", 32'(core_rst), 1);
    tick;
    chk("core_rst pulse", 32'(core_rst), 0);
    rd(9'h004, 32'h8, 2'b00, "status soft");
    rd(9'h008, 32'hFFFFFF80, 2'b00, "result kept");
    rd(9'h01C, 32'd1, 2'b00, "count kept");
    rd(9'h00C, 32'd5, 2'b00, "latency kept");
    w(9'h100, 32'h0000BEEF, 2'b00, "feat0 unlocked");
    rd(9'h100, 32'h0000BEEF, 2'b00, "feat0 new");
    chk("start pulses final", 32'(starts), 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
